fifo_width_conv: RTL and testbench
==================================

Name: fifo_width_conv

Overview:
- Synchronous FIFO with 2:1 width conversion: full-width words are written in, half-width words are read out.
- Each stored word is read out as two half-words, low half first, then high half.
- Used as a serialiser between a wide producer and a narrow consumer, in a single clock domain.

Parameters:
- DATA_WIDTH, 8: write word width. Must be even and at least 2.
- ADDR_WIDTH, 2: word-address bits. Storage depth is 2**ADDR_WIDTH words.
- R_DATA_WIDTH, DATA_WIDTH/2: read width. Derived localparam, not overridable.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- wr  in  1  write strobe; pushes w_data on a rising edge when not full.
- w_data  in  DATA_WIDTH  write word.
- rd  in  1  read strobe; pops one half-word on a rising edge when not empty.
- r_data  out  R_DATA_WIDTH  current head half-word (show-ahead).
- empty  out  1  no unread half-words remain.
- full  out  1  all word slots are occupied.

Behaviour:
- Storage: 2**ADDR_WIDTH x DATA_WIDTH register array, cleared to 0 on reset.
- Write pointer w_ptr is ADDR_WIDTH+1 bits; the MSB is the wrap bit.
- Read pointer r_ptr is ADDR_WIDTH+2 bits:
  - bit 0 is the half select (0 = low half, 1 = high half);
  - bits [ADDR_WIDTH:1] are the word index;
  - the MSB is the wrap bit.
- Reset (reset=0, asynchronous): w_ptr=0, r_ptr=0, empty=1, full=0, r_data=0.
- Status outputs are pure functions of registered pointers, with no combinational path from rd/wr:
  - empty = (r_ptr == {w_ptr, 1'b0});
  - full = (r_ptr[ADDR_WIDTH+1:1] word index and wrap bit are the opposite-wrap match of w_ptr), i.e. word indices equal and wrap bits differ.
- r_data is combinational: the selected half of mem[r_ptr word index], with bit 0 choosing low or high half. It is valid whenever empty=0. When empty=1 it shows the stale slot contents, which are 0 after reset.
- Write: on a rising edge with wr=1 and full=0:
  - mem[w_ptr index] <= w_data;
  - w_ptr increments.
- Write with full=1 is ignored; no state changes.
- Read: on a rising edge with rd=1 and empty=0, r_ptr increments by 1. The sequence is low half, high half, then the next word.
- Read with empty=1 is ignored.
- A word slot is freed only after its high half has been read. A partially read word still counts toward full.
- Latency:
  - a written word appears on r_data the cycle after the write edge, and empty deasserts the same cycle;
  - full/empty update on the edge after the causing operation.
- Simultaneous rd and wr:
  - both are evaluated against the pre-edge flags;
  - when neither flag blocks, both take effect;
  - when full=1, the write is dropped even if the read frees a slot;
  - when empty=1, the write is accepted and the read is dropped.
- Wrap-around: both pointers wrap naturally at their full widths; no special handling.
- Reset mid-operation flushes all contents and returns to the reset state immediately.
- Capacity: 2**ADDR_WIDTH words, i.e. 2**(ADDR_WIDTH+1) half-word reads before empty.

Decomposition:
- No shared package is needed. R_DATA_WIDTH and the pointer widths are local derived constants.
- Natural sub-module: fifo_width_conv_ctrl. It owns the pointers, the full/empty logic and the write/read enables, and exports the write address plus the read address with half select.
- The top level holds the register array and the r_data mux.

Test Plan:
- Reset, then idle -> empty=1, full=0, r_data=4'h0; rd=1 while empty leaves r_ptr unchanged.
- Single write w_data=8'hA5, then 2 reads -> r_data=4'h5 with empty=0; after the first read r_data=4'hA; after the second read empty=1.
- Hold wr=1 with w_data=8'h01 for 10 cycles -> full=1 after the 4th write; writes 5-10 are dropped; then wr=1 with 8'h03 is also dropped.
- From full (4 x 8'h01), hold rd=1 for 10 cycles -> r_data sequence 1,0,1,0,1,0,1,0, with full=0 after the 2nd read and empty=1 after the 8th read; later reads are ignored.
- Write 8'h80 and 8'h30, read 1 half (full stays accurate), then write 2 more words -> full=1. Read order is 0,8,0,3, then the new words' halves; exercises pointer wrap.
- Simultaneous rd+wr at mid-level, at empty (write only) and at full (read only) -> occupancy and flags match the rules above; assert reset mid-stream -> empty=1, full=0, r_data=0 immediately.

Source files
------------

// File: rtl/fifo_width_conv_ctrl.sv
// Pointer and status control for the 2:1 width-converting FIFO.
// Write pointer counts words; read pointer counts half-words (bit 0 is the half select).
module fifo_width_conv_ctrl #(
  parameter int unsigned ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic                  rd,
  output logic                  w_en,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  r_half,
  output logic                  empty,
  output logic                  full
);

  localparam int unsigned WPtrWidth = ADDR_WIDTH + 1;
  localparam int unsigned RPtrWidth = ADDR_WIDTH + 2;

  logic [WPtrWidth-1:0] w_ptr_q, w_ptr_d;
  logic [RPtrWidth-1:0] r_ptr_q, r_ptr_d;
  logic                 r_en;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_ptr_q <= '0;
      r_ptr_q <= '0;
    end else begin
      w_ptr_q <= w_ptr_d;
      r_ptr_q <= r_ptr_d;
    end
  end

  // Both flags come only from registered pointers, so rd/wr never reach them combinationally.
  assign empty = (r_ptr_q == {w_ptr_q, 1'b0});
  assign full  = (r_ptr_q[RPtrWidth-1:1] == {~w_ptr_q[WPtrWidth-1], w_ptr_q[ADDR_WIDTH-1:0]});

  assign w_en = wr & ~full;
  assign r_en = rd & ~empty;

  always_comb begin
    w_ptr_d = w_ptr_q;
    r_ptr_d = r_ptr_q;
    if (w_en) w_ptr_d = w_ptr_q + 1'b1;
    if (r_en) r_ptr_d = r_ptr_q + 1'b1;
  end

  assign w_addr = w_ptr_q[ADDR_WIDTH-1:0];
  assign r_addr = r_ptr_q[ADDR_WIDTH:1];
  assign r_half = r_ptr_q[0];

endmodule

// File: rtl/fifo_width_conv.sv
// Synchronous FIFO that accepts full-width words and returns them as two half-words,
// low half first. Show-ahead read data.
module fifo_width_conv #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr,
  input  logic [DATA_WIDTH-1:0]     w_data,
  input  logic                      rd,
  output logic [DATA_WIDTH/2-1:0]   r_data,
  output logic                      empty,
  output logic                      full
);

  localparam int unsigned RDataWidth = DATA_WIDTH / 2;
  localparam int unsigned Depth      = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [Depth];
  logic                  w_en;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_half;

  fifo_width_conv_ctrl #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ctrl (
    .clk    (clk),
    .reset  (reset),
    .wr     (wr),
    .rd     (rd),
    .w_en   (w_en),
    .w_addr (w_addr),
    .r_addr (r_addr),
    .r_half (r_half),
    .empty  (empty),
    .full   (full)
  );

  // Storage is cleared on reset so r_data reads 0 while empty after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (w_en) begin
      mem_q[w_addr] <= w_data;
    end
  end

  assign r_data = r_half ? mem_q[r_addr][DATA_WIDTH-1:RDataWidth]
                         : mem_q[r_addr][RDataWidth-1:0];

endmodule

// File: tb/tb_fifo_width_conv.sv
// Directed self-checking bench for fifo_width_conv with hand-computed expectations.
module tb_fifo_width_conv;

  logic       clk;
  logic       reset;
  logic       wr;
  logic [7:0] w_data;
  logic       rd;
  logic [3:0] r_data;
  logic       empty;
  logic       full;

  int unsigned n_checks;
  int unsigned n_pass;

  fifo_width_conv #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (2)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .wr     (wr),
    .w_data (w_data),
    .rd     (rd),
    .r_data (r_data),
    .empty  (empty),
    .full   (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] seq_a [8];
  logic [3:0] seq_b [6];

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b0;
    wr       = 1'b0;
    rd       = 1'b0;
    w_data   = '0;
    seq_a    = '{4'h1, 4'h0, 4'h1, 4'h0, 4'h1, 4'h0, 4'h1, 4'h0};
    seq_b    = '{4'hC, 4'h5, 4'h7, 4'hE, 4'h2, 4'h4};

    repeat (3) tick();
    reset = 1'b1;
    tick();
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_rdata", r_data, 4'h0);

    // Read while empty is ignored.
    rd = 1'b1;
    tick();
    rd = 1'b0;
    check("rd_empty_empty", empty, 1);

    // Single word, two halves.
    wr = 1'b1; w_data = 8'hA5;
    tick();
    wr = 1'b0;
    check("one_lo", r_data, 4'h5);
    check("one_nempty", empty, 0);
    rd = 1'b1;
    tick();
    check("one_hi", r_data, 4'hA);
    check("one_hi_nempty", empty, 0);
    tick();
    rd = 1'b0;
    check("one_drained", empty, 1);

    // Fill and overflow.
    wr = 1'b1; w_data = 8'h01;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 2) check("fill3_nfull", full, 0);
      if (i == 3) check("fill4_full", full, 1);
    end
    w_data = 8'h03;
    tick();
    wr = 1'b0;
    check("ovf_full", full, 1);
    check("ovf_head", r_data, 4'h1);

    // Drain with rd held high.
    rd = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) check($sformatf("drain_d%0d", i), r_data, seq_a[i]);
      tick();
      if (i == 0) check("drain1_full", full, 1);
      if (i == 1) check("drain2_nfull", full, 0);
      if (i == 6) check("drain7_nempty", empty, 0);
      if (i == 7) check("drain8_empty", empty, 1);
    end
    rd = 1'b0;
    check("drain_end_empty", empty, 1);
    check("drain_end_full", full, 0);

    // Partial read keeps the slot occupied; pointers wrap here.
    wr = 1'b1; w_data = 8'h80; tick();
    w_data = 8'h30; tick();
    wr = 1'b0;
    check("wrap_head0", r_data, 4'h0);
    rd = 1'b1; tick(); rd = 1'b0;
    check("wrap_head8", r_data, 4'h8);
    check("wrap_nfull", full, 0);
    wr = 1'b1; w_data = 8'h5C; tick();
    w_data = 8'hE7; tick();
    wr = 1'b0;
    check("wrap_full", full, 1);

    // rd+wr at full: read frees a slot but the write is still dropped.
    rd = 1'b1; wr = 1'b1; w_data = 8'hFF;
    tick();
    rd = 1'b0; wr = 1'b0;
    check("rw_full_nfull", full, 0);
    check("rw_full_head", r_data, 4'h0);
    rd = 1'b1; tick(); rd = 1'b0;
    check("rw_full_head3", r_data, 4'h3);

    // rd+wr at mid-level: both take effect.
    rd = 1'b1; wr = 1'b1; w_data = 8'h42;
    tick();
    rd = 1'b0; wr = 1'b0;
    check("rw_mid_nempty", empty, 0);
    check("rw_mid_nfull", full, 0);
    rd = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("rw_mid_d%0d", i), r_data, seq_b[i]);
      tick();
    end
    rd = 1'b0;
    check("rw_mid_empty", empty, 1);

    // rd+wr at empty: write accepted, read dropped.
    rd = 1'b1; wr = 1'b1; w_data = 8'h69;
    tick();
    rd = 1'b0; wr = 1'b0;
    check("rw_empty_head", r_data, 4'h9);
    check("rw_empty_nempty", empty, 0);
    rd = 1'b1; tick(); rd = 1'b0;
    check("rw_empty_hi", r_data, 4'h6);

    // Asynchronous reset mid-stream.
    wr = 1'b1; w_data = 8'h11; tick();
    wr = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("arst_empty", empty, 1);
    check("arst_full", full, 0);
    check("arst_rdata", r_data, 4'h0);
    tick();
    reset = 1'b1;
    tick();
    check("arst_hold_empty", empty, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
